// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave backed by a word-addressed SRAM array.
// Independent read and write FSMs with programmable wait-state latency.
module axi_lite_sram #(
    parameter int          DEPTH  = 1024,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          RD_LAT = 1,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_LAT - 1);
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - BASE) >> 2);
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic [3:0]  r_cnt;
    logic [31:0] ar_q;
    logic [31:0] r_addr;
    logic        r_load;

    // In idle the address is still on the bus; afterwards use the latched copy.
    assign r_addr = (r_state == R_IDLE) ? araddr : ar_q;
    assign r_load = (r_next == R_RESP) && (r_state != R_RESP);

    // Read next-state decode.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (arvalid && arready)
                        r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
            R_WAIT: if (r_cnt == RD_LAST) r_next = R_RESP;
            R_RESP: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read state, registered handshake outputs and data sampled on entry to R_RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            ar_q    <= 32'd0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= OKAY;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_RESP);
            r_cnt   <= (r_state == R_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (arvalid && arready) ar_q <= araddr;
            if (r_load) begin
                if (in_range(r_addr)) begin
                    rdata <= mem[word_idx(r_addr)];
                    rresp <= OKAY;
                end else begin
                    rdata <= 32'd0;
                    rresp <= SLVERR;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [3:0]  w_cnt;
    logic        aw_got, w_got;
    logic        aw_got_n, w_got_n;
    logic [31:0] aw_q, wd_q;
    logic [3:0]  ws_q;
    logic        aw_hs, w_hs, have_aw, have_w;
    logic        commit;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign have_aw = aw_got || aw_hs;
    assign have_w  = w_got || w_hs;
    // A zero-latency commit can coincide with capture, so bypass the latches.
    assign wa      = aw_got ? aw_q : awaddr;
    assign wd      = w_got ? wd_q : wdata;
    assign ws      = w_got ? ws_q : wstrb;

    // Write next-state decode, commit strobe and capture flags.
    always_comb begin
        w_next   = w_state;
        commit   = 1'b0;
        aw_got_n = have_aw;
        w_got_n  = have_w;
        unique case (w_state)
            W_IDLE: if (have_aw && have_w) begin
                        if (WR_LAT == 0) begin
                            w_next = W_RESP;
                            commit = 1'b1;
                        end else begin
                            w_next = W_WAIT;
                        end
                    end
            W_WAIT: if (w_cnt == WR_LAST) begin
                        w_next = W_RESP;
                        commit = 1'b1;
                    end
            W_RESP: if (bready) begin
                        w_next   = W_IDLE;
                        aw_got_n = 1'b0;
                        w_got_n  = 1'b0;
                    end
            default: w_next = W_IDLE;
        endcase
    end

    // Write state, capture registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_q    <= 32'd0;
            wd_q    <= 32'd0;
            ws_q    <= 4'd0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            w_state <= w_next;
            w_cnt   <= (w_state == W_WAIT) ? w_cnt + 4'd1 : 4'd0;
            aw_got  <= aw_got_n;
            w_got   <= w_got_n;
            if (aw_hs) aw_q <= awaddr;
            if (w_hs) begin
                wd_q <= wdata;
                ws_q <= wstrb;
            end
            awready <= (w_next == W_IDLE) && !aw_got_n;
            wready  <= (w_next == W_IDLE) && !w_got_n;
            bvalid  <= (w_next == W_RESP);
            if (commit) bresp <= in_range(wa) ? OKAY : SLVERR;
        end
    end

    // Storage is never reset; byte lanes commit only under their strobe.
    always_ff @(posedge clk) begin
        if (commit && rst && in_range(wa)) begin
            for (int i = 0; i < 4; i++) begin
                if (ws[i]) mem[word_idx(wa)][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed scenarios plus
// randomized traffic compared against an associative-array memory model.
module tb_axi_lite_sram;

    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;

    logic        clk, rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] ref_mem [int];

    axi_lite_sram #(
        .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ok_addr(input logic [31:0] a);
        longint la, lb;
        la = {32'd0, a};
        lb = {32'd0, BASE};
        return (la >= lb) && (la < lb + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return ok_addr(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (!ok_addr(a)) return 32'd0;
        return ref_mem[widx(a)];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!ok_addr(a)) return;
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        ref_mem[widx(a)] = w;
    endtask

    // Called and returns at a falling edge.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output int lat);
        int n;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", {31'd0, arready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
        check("rvalid_seen", {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        int cyc, n;
        bit aw_sent, w_sent, aw_f, w_f;
        awaddr = a;
        wdata = d;
        wstrb = s;
        aw_sent = 0;
        w_sent = 0;
        cyc = 0;
        while (cyc < 100) begin
            if (!aw_sent && cyc >= aw_dly) begin awvalid = 1'b1; aw_sent = 1; end
            if (!w_sent && cyc >= w_dly) begin wvalid = 1'b1; w_sent = 1; end
            if (aw_sent && w_sent && !awvalid && !wvalid) break;
            aw_f = awvalid && awready;
            w_f = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (aw_f) awvalid = 1'b0;
            if (w_f) wvalid = 1'b0;
        end
        check("aw_w_accept", {30'd0, awvalid, wvalid}, 32'd0);
        awvalid = 1'b0;
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("bvalid_seen", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, a, last;
        logic [1:0]  r;
        int          lat, n;

        rst = 1'b0;
        {arvalid, rready, awvalid, wvalid, bready} = '0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ready", {29'd0, arready, awready, wready}, 32'd0);
        check("rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        rst = 1'b1;
        #1;
        check("ready_before_edge", {29'd0, arready, awready, wready}, 32'd0);
        @(negedge clk);
        check("ready_after_edge", {29'd0, arready, awready, wready}, 32'd7);

        // basic write then read
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        check("t1_bresp", r, 32'(exp_resp(32'h8000_0010)));
        axi_read(32'h8000_0010, d, r, lat);
        check("t1_rdata", d, exp_data(32'h8000_0010));
        check("t1_rresp", r, 32'd0);
        check("t1_latency", lat, RD_LAT + 1);

        // W leads AW by 3 cycles, partial strobe
        axi_write(32'h8000_0040, 32'h1122_3344, 4'hF, 0, 0, r);
        model_write(32'h8000_0040, 32'h1122_3344, 4'hF);
        axi_write(32'h8000_0040, 32'hAABB_CCDD, 4'b0101, 3, 0, r);
        model_write(32'h8000_0040, 32'hAABB_CCDD, 4'b0101);
        check("t2_bresp", r, 32'd0);
        axi_read(32'h8000_0040, d, r, lat);
        check("t2_rdata", d, exp_data(32'h8000_0040));

        // out-of-range boundaries
        last = BASE + 32'(4 * (DEPTH - 1));
        axi_write(BASE, 32'h0123_4567, 4'hF, 0, 0, r);
        model_write(BASE, 32'h0123_4567, 4'hF);
        axi_write(last, 32'h89AB_CDEF, 4'hF, 0, 0, r);
        model_write(last, 32'h89AB_CDEF, 4'hF);
        check("t3_last_bresp", r, 32'd0);
        axi_read(last, d, r, lat);
        check("t3_last_rdata", d, exp_data(last));
        axi_read(32'h7FFF_FFFC, d, r, lat);
        check("t3_below_rdata", d, 32'd0);
        check("t3_below_rresp", r, 32'(exp_resp(32'h7FFF_FFFC)));
        axi_read(BASE + 32'(4 * DEPTH), d, r, lat);
        check("t3_above_rdata", d, 32'd0);
        check("t3_above_rresp", r, 32'(exp_resp(BASE + 32'(4 * DEPTH))));
        axi_write(32'h7FFF_FFFC, 32'hA5A5_A5A5, 4'hF, 0, 0, r);
        check("t3_below_bresp", r, 32'd2);
        axi_write(BASE + 32'(4 * DEPTH), 32'hA5A5_A5A5, 4'hF, 1, 0, r);
        check("t3_above_bresp", r, 32'd2);
        axi_read(BASE, d, r, lat);
        check("t3_word0_kept", d, exp_data(BASE));
        axi_read(last, d, r, lat);
        check("t3_last_kept", d, exp_data(last));
        axi_read(32'h8000_0010, d, r, lat);
        check("t3_w4_kept", d, exp_data(32'h8000_0010));

        // read response back-pressure
        axi_write(32'h8000_0050, 32'hCAFE_F00D, 4'hF, 0, 1, r);
        model_write(32'h8000_0050, 32'hCAFE_F00D, 4'hF);
        araddr = 32'h8000_0050;
        arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check("t4_rvalid_hold", {31'd0, rvalid}, 32'd1);
            check("t4_rdata_hold", rdata, exp_data(32'h8000_0050));
            check("t4_arready_low", {31'd0, arready}, 32'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        check("t4_after_hs", {30'd0, arready, rvalid}, 32'd2);

        // same-edge read sample and write commit
        axi_write(32'h8000_0020, 32'h0, 4'hF, 0, 0, r);
        model_write(32'h8000_0020, 32'h0, 4'hF);
        check("t5_ready", {29'd0, arready, awready, wready}, 32'd7);
        araddr = 32'h8000_0020;
        awaddr = 32'h8000_0020;
        wdata = 32'h5;
        wstrb = 4'hF;
        {arvalid, awvalid, wvalid} = 3'b111;
        @(posedge clk);
        @(negedge clk);
        {arvalid, awvalid, wvalid} = 3'b000;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("t5_old_value", rdata, exp_data(32'h8000_0020));
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("t5_bresp", {31'd0, bvalid, bresp}, 32'd4);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        model_write(32'h8000_0020, 32'h5, 4'hF);
        axi_read(32'h8000_0020, d, r, lat);
        check("t5_new_value", d, exp_data(32'h8000_0020));

        // reset during pending read response and write wait
        axi_write(32'h8000_0060, 32'h7777_7777, 4'hF, 0, 0, r);
        model_write(32'h8000_0060, 32'h7777_7777, 4'hF);
        araddr = 32'h8000_0010;
        arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        awaddr = 32'h8000_0060;
        wdata = 32'h0;
        wstrb = 4'hF;
        {awvalid, wvalid} = 2'b11;
        @(posedge clk);
        @(negedge clk);
        {awvalid, wvalid} = 2'b00;
        check("t6_rvalid_pending", {30'd0, rvalid, bvalid}, 32'd2);
        rst = 1'b0;
        #1;
        check("t6_valid_drop", {30'd0, rvalid, bvalid}, 32'd0);
        check("t6_ready_drop", {29'd0, arready, awready, wready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_awready_release", {31'd0, awready}, 32'd0);
        @(negedge clk);
        check("t6_ready_after", {29'd0, arready, awready, wready}, 32'd7);
        check("t6_bvalid_after", {31'd0, bvalid}, 32'd0);
        axi_read(32'h8000_0060, d, r, lat);
        check("t6_target_kept", d, exp_data(32'h8000_0060));
        axi_read(32'h8000_0010, d, r, lat);
        check("t6_persist", d, exp_data(32'h8000_0010));

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            int op, idx;
            logic [3:0] s;
            op = $urandom_range(0, 2);
            idx = $urandom_range(0, 15);
            if (op == 0) begin
                a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
                d = $urandom;
                s = ref_mem.exists(idx) ? 4'($urandom_range(0, 15)) : 4'hF;
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
                model_write(a, d, s);
                check("rnd_bresp", r, 32'(exp_resp(a)));
            end else begin
                if (op == 1 && ref_mem.exists(idx))
                    a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
                else if ($urandom_range(0, 1) == 1)
                    a = $urandom & 32'h7FFF_FFFF;
                else
                    a = BASE + 32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFF);
                if (!ok_addr(a) && $urandom_range(0, 1) == 1) begin
                    axi_write(a, $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), r);
                    check("rnd_oor_bresp", r, 32'(exp_resp(a)));
                end else begin
                    axi_read(a, d, r, lat);
                    check("rnd_rdata", d, exp_data(a));
                    check("rnd_rresp", r, 32'(exp_resp(a)));
                    check("rnd_latency", lat, RD_LAT + 1);
                end
            end
        end
        foreach (ref_mem[k]) begin
            axi_read(BASE + 32'(k * 4), d, r, lat);
            check("final_sweep", d, ref_mem[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram.md
AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words of storage.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning wait cycles from AR handshake to rvalid; range 0-15.
REQ-004 SHALL have parameter WR_LAT, default 1, meaning wait cycles from AW+W capture to commit; range 0-15.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 araddr  input  32  read byte address.
REQ-009 arvalid / arready  input / output  1 / 1  read-address handshake.
REQ-010 rdata / rresp  output  32 / 2  read data / response (00 OKAY, 10 SLVERR).
REQ-011 rvalid / rready  output / input  1 / 1  read-data handshake.
REQ-012 awaddr  input  32  write byte address.
REQ-013 awvalid / awready  input / output  1 / 1  write-address handshake.
REQ-014 wdata / wstrb  input  32 / 4  write data / byte-lane enables.
REQ-015 wvalid / wready  input / output  1 / 1  write-data handshake.
REQ-016 bresp  output  2  write response (00 OKAY, 10 SLVERR).
REQ-017 bvalid / bready  output / input  1 / 1  write-response handshake.

Function
REQ-018 Read FSM and write FSM SHALL be independent; each accepts one transaction at a time.
REQ-019 Read FSM states: R_IDLE (arready=1), R_WAIT (counter), R_RESP (rvalid=1); no other read outputs asserted.
REQ-020 R_IDLE -> R_WAIT on arvalid&&arready, latching araddr; if RD_LAT=0, R_IDLE -> R_RESP directly.
REQ-021 R_WAIT SHALL count RD_LAT cycles then enter R_RESP; rvalid first high RD_LAT+1 cycles after the handshake edge.
REQ-022 Entering R_RESP SHALL register rdata/rresp; both SHALL stay stable while rvalid=1 and rready=0.
REQ-023 R_RESP -> R_IDLE on rvalid&&rready; arready returns high the following cycle (no back-to-back overlap).
REQ-024 Write FSM states: W_IDLE, W_WAIT, W_RESP.
REQ-025 In W_IDLE awready=!aw_got, wready=!w_got; AW and W SHALL be captured independently, in either order or in the same cycle.
REQ-026 W_IDLE -> W_WAIT when both captured (including capture in the current cycle); if WR_LAT=0, go directly to commit.
REQ-027 Commit SHALL occur on the edge entering W_RESP: each byte lane i written only if wstrb[i]=1; wstrb=0 writes nothing, still responds OKAY.
REQ-028 W_RESP asserts bvalid until bvalid&&bready, then -> W_IDLE, clearing aw_got/w_got.
REQ-029 Word index = (addr - BASE) >> 2; addr[1:0] ignored.
REQ-030 Address below BASE or index >= DEPTH: read returns rdata=0, rresp=10; write modifies nothing, bresp=10.
REQ-031 Read sample and write commit to the same word on the same edge: read SHALL return the pre-write value.
REQ-032 Storage SHALL not be reset; contents persist across reset.

Reset
REQ-033 While rst=0: both FSMs in idle, counters 0, aw_got=w_got=0, arready=awready=wready=rvalid=bvalid=0, rdata=0, rresp=00, bresp=00.
REQ-034 Ready outputs SHALL be registered; arready/awready/wready first rise one clock edge after rst deasserts.
REQ-035 Reset asserted mid-transaction SHALL abort it: no partial write commits; pending rvalid/bvalid drop immediately.

Verification
REQ-036 Write 32'hDEAD_BEEF to 32'h8000_0010 wstrb=F, then read it, RD_LAT=1 -> bresp=00, rdata=32'hDEAD_BEEF, rvalid 2 cycles after AR handshake.
REQ-037 W presented 3 cycles before AW, word preloaded 32'h1122_3344, wdata 32'hAABB_CCDD wstrb=4'b0101 -> readback 32'h11BB_33DD.
REQ-038 Read 32'h7FFF_FFFC and BASE+4*DEPTH -> rresp=10, rdata=0; write there -> bresp=10, no word changed.
REQ-039 rready held low 5 cycles in R_RESP -> rvalid, rdata stable 5 cycles; arready low until one cycle after handshake.
REQ-040 Same-edge read sample and write commit to 32'h8000_0020 (old 0, new 32'h5) -> read returns 0, later read returns 32'h5.
REQ-041 rst pulsed low during W_WAIT -> bvalid=0 immediately, target word unchanged, awready high one edge after release.
